// File: rtl/traffic_pkg.sv
// Shared traffic-controller definitions: lamp codes, dispatcher states, rollback word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package traffic_pkg;

  // Car lamp codes driven by the path controllers
  localparam logic [3:0] CAR_RED    = 4'b1000;
  localparam logic [3:0] CAR_YELLOW = 4'b0100;
  localparam logic [3:0] CAR_LEFT   = 4'b0010;
  localparam logic [3:0] CAR_GREEN  = 4'b0001;

  // Walk lamp codes driven by the path controllers
  localparam logic [1:0] WALK_RED   = 2'b10;
  localparam logic [1:0] WALK_GREEN = 2'b01;

  // Dispatcher FSM encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } disp_state_e;

  // Rollback word: bit3 = direction, bits2:0 = magnitude
  typedef struct packed {
    logic       dir;
    logic [2:0] mag;
  } rollback_t;

  // 7-bit counter increment that sticks at its maximum
  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v == 7'h7f) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/vip_debounce.sv
// Per-path VIP request debouncer: run counter plus sticky pending flag.
// Latency: pending sets on the DEBOUNCE-th consecutive high sample.
// Backpressure: none; pending holds until the grant clears it.
module vip_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic clr,
  output logic pending
);

  logic [6:0] run_q;
  logic [6:0] run_d;

  // Run length of the raw input, restarting whenever it drops
  always_comb begin
    run_d = raw ? sat_inc(run_q) : 7'd0;
  end

  // Latch a request once per run on reaching the threshold; a grant clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 7'd0;
      pending <= 1'b0;
    end else begin
      run_q <= run_d;
      if (clr)
        pending <= 1'b0;
      else if (run_d == 7'(DEBOUNCE))
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/vip_dispatcher.sv
// VIP preemption dispatcher: arbitrates debounced requests and drives isvip to both paths.
// Latency: grant one edge after pending; release on the edge entering RELEASE.
// Backpressure: waits in REQ for CAR_GREEN on the granted path, aborts after WAIT_MAX.
module vip_dispatcher
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int WAIT_MAX = 16,
  parameter int MIN_HOLD = 10,
  parameter int MAX_HOLD = 40,
  parameter int CLR_GAP  = 4
) (
  input  logic       clk,
  input  logic       start,
  input  logic [1:0] vip_req,
  input  logic [1:0] vip_clear,
  input  logic [3:0] car_traffic_0,
  input  logic [3:0] car_traffic_1,
  input  logic [3:0] prev_counter_0,
  input  logic [3:0] prev_counter_1,
  output logic       isvip,
  output logic       vip_path_index,
  output logic [3:0] rollback_cnt_0,
  output logic [3:0] rollback_cnt_1,
  output logic       busy,
  output logic       abort
);

  localparam logic [6:0] WAIT_LIM = 7'(WAIT_MAX);
  localparam logic [6:0] MIN_LIM  = 7'(MIN_HOLD);
  localparam logic [6:0] MAX_LIM  = 7'(MAX_HOLD);
  localparam logic [6:0] GAP_LIM  = 7'(CLR_GAP);

  disp_state_e state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [1:0]  pending;
  logic [1:0]  pend_clr;
  logic        grant_d;
  logic        grant_path;
  logic        abort_d;
  logic        isvip_d;
  logic        busy_d;
  logic        idx_d;
  logic        last_q, last_d;
  logic        rb_upd;
  logic [3:0]  lamp_sel;
  logic        clr_sel;
  rollback_t   rb0_q, rb1_q;

  genvar g;
  for (g = 0; g < 2; g++) begin : g_deb
    vip_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk     (clk),
      .rst_n   (start),
      .raw     (vip_req[g]),
      .clr     (pend_clr[g]),
      .pending (pending[g])
    );
  end

  // Arbitration and granted-path selection of lamp and clear sensor
  always_comb begin
    grant_path = (&pending) ? ~last_q : pending[1];
    lamp_sel   = vip_path_index ? car_traffic_1 : car_traffic_0;
    clr_sel    = vip_path_index ? vip_clear[1] : vip_clear[0];
  end

  // FSM state and shared phase counter
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q <= IDLE;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: counter is 1 in the first cycle of each phase
  always_comb begin
    state_d = state_q;
    cnt_d   = sat_inc(cnt_q);
    grant_d = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 7'd0;
        if (|pending) begin
          state_d = REQ;
          cnt_d   = 7'd1;
          grant_d = 1'b1;
        end
      end
      REQ: begin
        if (lamp_sel == CAR_GREEN) begin
          state_d = HOLD;
          cnt_d   = 7'd1;
        end else if (cnt_q >= WAIT_LIM) begin
          state_d = RELEASE;
          cnt_d   = 7'd1;
          abort_d = 1'b1;
        end
      end
      HOLD: begin
        if ((cnt_q >= MAX_LIM) || (clr_sel && (cnt_q >= MIN_LIM))) begin
          state_d = RELEASE;
          cnt_d   = 7'd1;
        end
      end
      RELEASE: begin
        if (cnt_q >= GAP_LIM) begin
          if (|pending) begin
            state_d = REQ;
            cnt_d   = 7'd1;
            grant_d = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = 7'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 7'd0;
      end
    endcase
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    isvip_d  = (state_d == REQ) || (state_d == HOLD);
    busy_d   = (state_d != IDLE);
    idx_d    = grant_d ? grant_path : vip_path_index;
    last_d   = grant_d ? grant_path : last_q;
    pend_clr = grant_d ? (grant_path ? 2'b10 : 2'b01) : 2'b00;
    rb_upd   = (state_q == REQ) || (state_q == HOLD);
  end

  // Registered outputs; reset drops isvip without waiting for a clock
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      isvip          <= 1'b0;
      busy           <= 1'b0;
      abort          <= 1'b0;
      vip_path_index <= 1'b0;
      last_q         <= 1'b1;
    end else begin
      isvip          <= isvip_d;
      busy           <= busy_d;
      abort          <= abort_d;
      vip_path_index <= idx_d;
      last_q         <= last_d;
    end
  end

  // Rollback words track the controllers while preempting, frozen otherwise
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      rb0_q <= '0;
      rb1_q <= '0;
    end else if (rb_upd) begin
      rb0_q <= rollback_t'(prev_counter_0);
      rb1_q <= rollback_t'(prev_counter_1);
    end
  end

  assign rollback_cnt_0 = rb0_q;
  assign rollback_cnt_1 = rb1_q;

endmodule
